mips_multicycle_control: RTL and testbench
==========================================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum consecutive MemReady-low cycles tolerated in a memory state; 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port Op  input  6  instruction opcode (IR[31:26]), sampled in DECODE.
REQ-005 SHALL have port MemReady  input  1  memory completion handshake for the current access.
REQ-006 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  multicycle datapath controls.
REQ-007 SHALL have ports PCSource, ALUOp, ALUSrcB  output  2 each  mux selects; ALUOp feeds the ALU control decoder.
REQ-008 SHALL have port State  output  4  current state encoding, for debug.
REQ-009 SHALL have port Err  output  1  high while in ERROR.

Function
REQ-010 States SHALL be encoded FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ERROR=15.
REQ-011 Any output not named for a state SHALL be 0 in that state.
REQ-012 FETCH: MemRead=1, ALUSrcB=01; IRWrite=1 and PCWrite=1 only in the cycle MemReady=1; FETCH->DECODE on MemReady=1, else hold.
REQ-013 DECODE: ALUSrcB=11; next state by Op: 100011 or 101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, any other -> ERROR.
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10; next MEMRD if Op=100011, MEMWR if Op=101011.
REQ-015 MEMRD: MemRead=1, IorD=1; MEMRD->MEMWB on MemReady=1, else hold.
REQ-016 MEMWB: MemtoReg=1, RegWrite=1; next FETCH.
REQ-017 MEMWR: MemWrite=1, IorD=1; MEMWR->FETCH on MemReady=1, else hold.
REQ-018 EXEC: ALUSrcA=1, ALUOp=10; next ALUWB. ALUWB: RegDst=1, RegWrite=1; next FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
REQ-020 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-021 ERROR: Err=1, all other controls 0, absorbing until reset.
REQ-022 A wait counter SHALL clear on every state change and increment each cycle spent in FETCH, MEMRD or MEMWR with MemReady=0.
REQ-023 If MAX_WAIT>0 and MemReady=0 while the counter equals MAX_WAIT-1, the next state SHALL be ERROR.
REQ-024 MemReady=1 in that same cycle SHALL take priority: normal transition, no error.
REQ-025 Op SHALL be ignored outside DECODE and MEMADR; a write strobe SHALL never assert two cycles for one handshake.

Reset
REQ-026 reset_n=0 SHALL immediately force State=FETCH and clear the wait counter, independent of clk.
REQ-027 During reset all outputs SHALL be 0 except MemRead=1 and ALUSrcB=01, the FETCH values with MemReady ignored; Err=0.
REQ-028 Reset asserted mid-instruction SHALL abandon it; after release the first edge evaluates FETCH.

Configuration
REQ-029 Macro MIPS_CTRL_ADDI_EN defined: DECODE with Op=001000 SHALL go to ADDIEX (ALUSrcA=1, ALUSrcB=10, ALUOp=00), then ADDIWB (RegWrite=1, RegDst=0, MemtoReg=0), then FETCH.
REQ-030 Macro undefined: Op=001000 SHALL be treated as unknown (DECODE->ERROR); states 10-11 SHALL be unreachable.

Verification
REQ-031 lw (Op=100011), MemReady=1 always -> State 0,1,2,3,4,0; RegWrite=1 only in state 4; 5 cycles.
REQ-032 sw (Op=101011), MemReady low 3 cycles in MEMWR -> MemWrite high 4 cycles, then FETCH; Err=0.
REQ-033 beq (Op=000100) -> State 0,1,8,0; PCWriteCond=1, ALUOp=01 in state 8; R-type (000000) -> 0,1,6,7,0 with ALUOp=10 in state 6.
REQ-034 MAX_WAIT=15, MemReady held 0 in FETCH -> ERROR after 15 cycles, Err=1; MemReady=1 on cycle 15 -> DECODE, no error.
REQ-035 Op=001000 -> 0,1,10,11,0 with macro; 0,1,15 and Err=1 without.
REQ-036 reset_n pulsed low in MEMRD between edges -> State=0 immediately, counter 0; fresh fetch after release.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM (lw/sw/R-type/beq/j) with a memory-wait timeout.
// Optional addi support is enabled by defining MIPS_CTRL_ADDI_EN.
module mips_multicycle_control #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] State,
  output logic       Err
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_ERROR  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          mem_state;
  logic          timeout;

  assign State     = state;
  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // Timeout only fires while still stalled; a MemReady in the same cycle wins.
  assign timeout   = (MAX_WAIT > 0) && mem_state && !MemReady &&
                     (wait_cnt == CW'(MAX_WAIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (mem_state && !MemReady)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // NOTE: every output and state_nxt gets a default before the case so no
  // path leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_nxt   = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    Err         = 1'b0;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          // Gated by reset_n so a held reset never fires the IR/PC strobes.
          IRWrite   = reset_n;
          PCWrite   = reset_n;
          state_nxt = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_ERROR;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      state_nxt = S_ADDIEX;
`endif
          default:      state_nxt = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (Op == OP_LW)      state_nxt = S_MEMRD;
        else if (Op == OP_SW) state_nxt = S_MEMWR;
        else                  state_nxt = S_ERROR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady)     state_nxt = S_MEMWB;
        else if (timeout) state_nxt = S_ERROR;
      end
      S_MEMWB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady)     state_nxt = S_FETCH;
        else if (timeout) state_nxt = S_ERROR;
      end
      S_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_nxt   = S_FETCH;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        state_nxt = S_FETCH;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
`endif
      S_ERROR: begin
        Err = 1'b1;
      end
      default: state_nxt = S_ERROR;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: next-state expectations are
// queued when inputs are driven and compared after the clock edge.
module tb_mips_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, Err;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] State;
  logic [16:0] ctrl_vec;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cur_exp;

  mips_multicycle_control #(.MAX_WAIT(15)) dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .State(State), .Err(Err)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                     IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp,
                     ALUSrcB, Err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word for a state, straight from the state table.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] s, input logic mr, input logic rstn);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, err;
    logic [1:0] pcs, aop, asb;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, err} = '0;
    {pcs, aop, asb} = '0;
    case (s)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr & rstn; pcw = mr & rstn; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      4'd15: err = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, aop, asb, err};
  endfunction

  // Drive one cycle's inputs, check this cycle's controls, queue the expected
  // next state and compare it after the edge. Entered and left at posedge+1.
  task automatic step(input logic [5:0] op, input logic mr, input logic [3:0] nxt);
    logic [3:0] e;
    @(negedge clk);
    Op = op;
    MemReady = mr;
    #1;
    check($sformatf("ctrl_s%0d", cur_exp), {15'd0, ctrl_vec}, {15'd0, exp_ctrl(cur_exp, mr, 1'b1)});
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("next_from_s%0d", cur_exp), {28'd0, State}, {28'd0, e});
    cur_exp = e;
  endtask

  // Reset pulse placed between edges; called at posedge+1.
  task automatic pulse_reset();
    #1;
    reset_n  = 1'b0;
    MemReady = 1'b1;
    Op       = OP_BAD;
    #1;
    check("rst_state", {28'd0, State}, 32'd0);
    check("rst_ctrl", {15'd0, ctrl_vec}, {15'd0, exp_ctrl(4'd0, 1'b1, 1'b0)});
    #1;
    reset_n  = 1'b1;
    MemReady = 1'b0;
    cur_exp  = 4'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    Op       = OP_BAD;
    MemReady = 1'b1;
    cur_exp  = 4'd0;
    #1;
    check("por_state", {28'd0, State}, 32'd0);
    check("por_ctrl", {15'd0, ctrl_vec}, {15'd0, exp_ctrl(4'd0, 1'b1, 1'b0)});
    @(posedge clk);
    #1;
    check("por_hold", {28'd0, State}, 32'd0);
    pulse_reset();

    // lw, memory always ready: 0,1,2,3,4,0
    step(OP_LW, 1, 1); step(OP_LW, 1, 2); step(OP_LW, 1, 3);
    step(6'($urandom), 1, 4); step(6'($urandom), 1, 0);

    // sw with MEMWR stalled three cycles: MemWrite high four cycles
    step(OP_SW, 1, 1); step(OP_SW, 1, 2); step(OP_SW, 1, 5);
    for (int i = 0; i < 3; i++) step(6'($urandom), 0, 5);
    step(OP_SW, 1, 0);
    check("sw_no_err", {31'd0, Err}, 32'd0);

    // beq, R-type, jump
    step(OP_BEQ, 1, 1); step(OP_BEQ, 1, 8); step(OP_BEQ, 1, 0);
    step(OP_RTYPE, 1, 1); step(OP_RTYPE, 1, 6); step(OP_RTYPE, 1, 7); step(OP_RTYPE, 1, 0);
    step(OP_J, 1, 1); step(OP_J, 1, 9); step(OP_LW, 1, 0);

    // MemReady on the 15th stalled FETCH cycle wins over the timeout
    for (int i = 0; i < 14; i++) step(6'($urandom), 0, 0);
    step(OP_RTYPE, 1, 1); step(OP_RTYPE, 1, 6); step(OP_RTYPE, 1, 7); step(OP_RTYPE, 1, 0);

    // addi: optional path or unknown opcode
    step(OP_ADDI, 1, 1);
`ifdef MIPS_CTRL_ADDI_EN
    step(OP_ADDI, 1, 10); step(OP_ADDI, 1, 11); step(OP_ADDI, 1, 0);
`else
    step(OP_ADDI, 1, 15);
    check("addi_err", {31'd0, Err}, 32'd1);
    pulse_reset();
`endif

    // Unknown opcode goes to ERROR, which absorbs everything
    step(OP_BAD, 1, 1); step(OP_BAD, 1, 15);
    step(OP_LW, 1, 15); step(OP_RTYPE, 0, 15);
    pulse_reset();

    // FETCH stalled 15 cycles times out
    for (int i = 0; i < 14; i++) step(6'($urandom), 0, 0);
    step(OP_LW, 0, 15);
    check("timeout_err", {31'd0, Err}, 32'd1);
    pulse_reset();

    // Reset mid-MEMRD abandons lw and clears the wait counter
    step(OP_LW, 1, 1); step(OP_LW, 1, 2); step(OP_LW, 1, 3);
    for (int i = 0; i < 5; i++) step(OP_LW, 0, 3);
    pulse_reset();
    for (int i = 0; i < 14; i++) step(6'($urandom), 0, 0);
    step(OP_LW, 0, 15);
    pulse_reset();

    // Fresh instruction after reset
    step(OP_J, 1, 1); step(OP_J, 1, 9); step(OP_J, 1, 0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
